sseg_to_bcd_scan: RTL and testbench
===================================

Name: sseg_to_bcd_scan

Overview:
- Receiver for a multiplexed seven-segment display bus: the other end of our BCD-to-seven-segment encoding.
- Samples one-hot digit select plus segment lines and requires each pattern to be stable before accepting it.
- Decodes each accepted pattern back to a BCD nibble and presents a full multi-digit frame through a valid/ready handshake.
- Used for display loop-back checking and panel snooping.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CNT, 3, consecutive identical qualified samples required to accept a pattern (2..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sample_en  in  1  sample strobe; inputs are considered only when 1.
- dig_sel  in  NUM_DIGITS  active-high digit select, expected one-hot.
- sseg  in  7  segments, active-high, sseg[6]=a down to sseg[0]=g.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts frame.
- bcd_out  out  4*NUM_DIGITS  digit i on bits [4i+3:4i].
- blank  out  NUM_DIGITS  digit i was dark (all segments off).
- err  out  NUM_DIGITS  digit i pattern not a legal code.
- overrun  out  1  one-cycle pulse when an uncollected shadow digit is overwritten.

Behaviour:
- Reset (rst_n=0 at an edge): out_valid, bcd_out, blank, err, overrun = 0. Internal state is also cleared: shadow regs, update mask, stability counter, prev_sel, prev_seg. Any partial frame is discarded. Reset overrides all other activity.
- Qualified sample: sample_en=1 and dig_sel exactly one-hot. If sample_en=1 and dig_sel is not one-hot (zero or multi-hot), the sample is ignored and the counter is cleared to 0. sample_en=0 leaves all tracking state unchanged.
- Stability tracking, on each qualified sample:
  - If {dig_sel,sseg} equals {prev_sel,prev_seg}, the counter increments, saturating at STABLE_CNT.
  - Otherwise the counter is set to 1 and prev is loaded.
- Commit: occurs on the sample where the counter becomes exactly STABLE_CNT, so exactly once per stable run. A run interrupted by a different sample restarts from 1.
- Decode table (sseg -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - 0000000 -> nibble F, blank bit 1
  - any other pattern -> nibble E, err bit 1
  - Legal digits have blank=0, err=0.
- Commit action:
  - Writes the shadow nibble, blank and err for digit = index of dig_sel, and sets mask bit.
  - If that mask bit was already 1, overrun pulses high the next cycle. The latest value wins.
- Transfer:
  - Fires when the registered mask is all ones and (out_valid=0 or out_ready=1).
  - Shadow is copied to the outputs, out_valid=1, and mask_next = commit_bit only (old mask cleared).
  - Outputs take the registered shadow. A commit in the transfer cycle lands in the next frame.
- Handshake:
  - Accept occurs when out_valid and out_ready are both 1. After accept with no transfer, out_valid drops next cycle.
  - While out_valid=1 and out_ready=0, bcd_out/blank/err are held stable.
  - Back-to-back frames are allowed (accept and transfer in the same cycle).
- Latency: commit is registered on the STABLE_CNT-th qualified sample edge. out_valid rises one clk after the last mask bit is set (if not stalled).
- out_ready is ignored while out_valid=0.

Test Plan:
- NUM_DIGITS=4, STABLE_CNT=3, out_ready=1: drive digit0..3 with patterns for 1,2,3,4 for 3 sample_en cycles each -> one out_valid pulse, bcd_out=16'h4321, blank=0, err=0, overrun=0.
- Digit0 sampled 0110000 twice, then 1111110 three times -> digit0 commits 0 not 1; the frame shows nibble 0 for digit0.
- Digit2 given 1000000, digit3 given 0000000, others valid -> bcd_out[11:8]=E with err=4'b0100; bcd_out[15:12]=F with blank=4'b1000.
- out_ready=0 after the first frame 16'h4321; second frame 8765 is fully committed, then digit0 is recommitted as 9 -> outputs hold 4321 and overrun pulses once. Raising out_ready -> accept, then next cycle bcd_out=16'h8769.
- dig_sel=4'b0011 with sample_en=1 between two identical digit1 samples -> the counter restarts and no commit occurs until 3 further clean samples.
- rst_n=0 for one edge after 2 of 4 digits committed -> all outputs 0. The next full frame contains only post-reset digits, with no stale bits.

Source files
------------

// File: rtl/sseg_to_bcd_scan.sv
// ---------------------------------------------------------------------------
// sseg_to_bcd_scan
//
// Receiver for a multiplexed seven-segment display bus. Each digit pattern
// (one-hot digit select plus segment lines) must be seen STABLE_CNT times in a
// row on qualified samples before it is accepted. Accepted patterns are
// decoded back to BCD and written into a shadow frame. Once every digit has
// been committed, the shadow frame is handed to the consumer through a
// valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   sample_en  sample strobe; the bus is looked at only when 1
//   dig_sel    active-high digit select, expected one-hot
//   sseg       segments a..g on sseg[6]..sseg[0], active-high
//   out_valid  a frame is presented on bcd_out/blank/err
//   out_ready  consumer accepts the presented frame
//   bcd_out    digit i on bits [4i+3:4i]
//   blank      digit i was dark (all segments off)
//   err        digit i was not a legal digit code
//   overrun    one-cycle pulse when an uncollected shadow digit is replaced
// ---------------------------------------------------------------------------
module sseg_to_bcd_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic [6:0]              sseg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    overrun
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] nibble;
    } dec_t;

    // Segment pattern back to BCD. Dark digits decode to F, anything that is
    // not one of the ten digit shapes decodes to E.
    function automatic dec_t decode(input logic [6:0] seg);
        dec_t d;
        d = '{blank: 1'b0, err: 1'b0, nibble: 4'h0};
        unique case (seg)
            7'b1111110: d.nibble = 4'd0;
            7'b0110000: d.nibble = 4'd1;
            7'b1101101: d.nibble = 4'd2;
            7'b1111001: d.nibble = 4'd3;
            7'b0110011: d.nibble = 4'd4;
            7'b1011011: d.nibble = 4'd5;
            7'b1011111: d.nibble = 4'd6;
            7'b1110000: d.nibble = 4'd7;
            7'b1111111: d.nibble = 4'd8;
            7'b1111011: d.nibble = 4'd9;
            7'b0000000: begin d.nibble = 4'hF; d.blank = 1'b1; end
            default:    begin d.nibble = 4'hE; d.err   = 1'b1; end
        endcase
        return d;
    endfunction

    // Tracking state
    logic [NUM_DIGITS-1:0]   prev_sel;
    logic [6:0]              prev_seg;
    logic [3:0]              cnt;

    // Frame under assembly
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [NUM_DIGITS-1:0]   mask;

    // Next-state and control terms
    logic                    one_hot;
    logic                    qualified;
    logic                    match;
    logic [3:0]              cnt_nxt;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   commit_bit;
    logic [IW-1:0]           sel_idx;
    logic                    transfer;
    logic [NUM_DIGITS-1:0]   mask_nxt;
    logic                    overrun_nxt;
    dec_t                    dec;

    // NOTE: every signal assigned in this block gets a default at the top, so
    // no path through the ifs can leave one unassigned and infer a latch.
    always_comb begin
        one_hot     = ($countones(dig_sel) == 1);
        qualified   = sample_en && one_hot;
        match       = ({dig_sel, sseg} == {prev_sel, prev_seg});
        dec         = decode(sseg);
        cnt_nxt     = cnt;
        sel_idx     = '0;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) sel_idx = IW'(i);
        end

        if (sample_en && !one_hot) begin
            cnt_nxt = '0;
        end else if (qualified) begin
            if (!match)
                cnt_nxt = 4'd1;
            else if (cnt != 4'(STABLE_CNT))
                cnt_nxt = cnt + 4'd1;
        end

        // The counter can only reach STABLE_CNT by stepping up from one below
        // it, which makes commit fire exactly once per stable run.
        commit      = qualified && match && (cnt == 4'(STABLE_CNT - 1));
        commit_bit  = commit ? dig_sel : '0;

        transfer    = (&mask) && (!out_valid || out_ready);
        mask_nxt    = transfer ? commit_bit : (mask | commit_bit);

        // A digit replaced in the transfer cycle was just collected, so it is
        // not an overrun.
        overrun_nxt = commit && ((mask & dig_sel) != '0) && !transfer;
    end

    // NOTE: all state, including the shadow frame, is cleared on reset so a
    // post-reset frame can never carry digits from before the reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_sel     <= '0;
            prev_seg     <= '0;
            cnt          <= '0;
            shadow_bcd   <= '0;
            shadow_blank <= '0;
            shadow_err   <= '0;
            mask         <= '0;
            out_valid    <= 1'b0;
            bcd_out      <= '0;
            blank        <= '0;
            err          <= '0;
            overrun      <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
            overrun <= overrun_nxt;

            if (qualified && !match) begin
                prev_sel <= dig_sel;
                prev_seg <= sseg;
            end

            if (commit) begin
                shadow_bcd[4*sel_idx +: 4] <= dec.nibble;
                shadow_blank[sel_idx]      <= dec.blank;
                shadow_err[sel_idx]        <= dec.err;
            end

            // Outputs take the registered shadow; a commit in this same cycle
            // belongs to the next frame.
            if (transfer) begin
                out_valid <= 1'b1;
                bcd_out   <= shadow_bcd;
                blank     <= shadow_blank;
                err       <= shadow_err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_to_bcd_scan.sv
// ---------------------------------------------------------------------------
// tb_sseg_to_bcd_scan
//
// Self-checking bench for sseg_to_bcd_scan. A behavioural model tracks run
// lengths of identical qualified samples, a per-digit pending frame and the
// presented frame; its outputs are compared with the DUT on every falling
// edge. Directed sequences add literal expectations, then randomized traffic
// runs against the model.
// ---------------------------------------------------------------------------
module tb_sseg_to_bcd_scan;

    localparam int ND = 4;
    localparam int SC = 3;

    localparam logic [6:0] SEG [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sample_en = 1'b0;
    logic [ND-1:0]   dig_sel = '0;
    logic [6:0]      sseg = '0;
    logic            out_ready = 1'b1;
    logic            out_valid;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
    logic            overrun;

    int checks = 0;
    int errors = 0;

    sseg_to_bcd_scan #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .dig_sel(dig_sel),
        .sseg(sseg), .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .blank(blank), .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [ND-1:0]   run_sel = '0;
    logic [6:0]      run_seg = '0;
    int              run_len = 0;
    int              pend_val [ND];
    bit              pend_blank [ND];
    bit              pend_err [ND];
    bit              have [ND];
    bit              m_valid;
    logic [4*ND-1:0] m_bcd;
    logic [ND-1:0]   m_blank, m_err;
    bit              m_overrun;
    bit              model_started = 0;

    function automatic void model_decode(input logic [6:0] s, output int v,
                                         output bit b, output bit e);
        v = 14; b = 0; e = 1;
        if (s == 7'd0) begin v = 15; b = 1; e = 0; end
        for (int d = 0; d < 10; d++)
            if (s == SEG[d]) begin v = d; b = 0; e = 0; end
    endfunction

    always @(posedge clk) begin
        bit commit, full, xfer;
        int idx, v;
        bit b, e;
        model_started = 1;
        if (!rst_n) begin
            run_sel = '0; run_seg = '0; run_len = 0;
            for (int i = 0; i < ND; i++) begin
                pend_val[i] = 0; pend_blank[i] = 0; pend_err[i] = 0; have[i] = 0;
            end
            m_valid = 0; m_bcd = '0; m_blank = '0; m_err = '0; m_overrun = 0;
        end else begin
            commit = 0;
            idx = 0;
            if (sample_en) begin
                if ($countones(dig_sel) != 1) begin
                    run_len = 0;
                end else if (dig_sel == run_sel && sseg == run_seg) begin
                    run_len++;
                    commit = (run_len == SC);
                end else begin
                    run_sel = dig_sel; run_seg = sseg; run_len = 1;
                end
            end
            for (int i = 0; i < ND; i++) if (dig_sel[i]) idx = i;

            full = 1;
            for (int i = 0; i < ND; i++) if (!have[i]) full = 0;
            xfer = full && (!m_valid || out_ready);
            if (xfer) begin
                m_valid = 1;
                for (int i = 0; i < ND; i++) begin
                    m_bcd[4*i +: 4] = 4'(pend_val[i]);
                    m_blank[i] = pend_blank[i];
                    m_err[i] = pend_err[i];
                    have[i] = 0;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end

            m_overrun = 0;
            if (commit) begin
                model_decode(sseg, v, b, e);
                m_overrun = have[idx];
                pend_val[idx] = v; pend_blank[idx] = b; pend_err[idx] = e;
                have[idx] = 1;
            end
        end
    end

    // One compare process, every cycle, on the falling edge.
    int ov_seen = 0;
    always @(negedge clk) begin
        if (model_started) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("bcd_out",   32'(bcd_out),   32'(m_bcd));
            check("blank",     32'(blank),     32'(m_blank));
            check("err",       32'(err),       32'(m_err));
            check("overrun",   32'(overrun),   32'(m_overrun));
            if (overrun === 1'b1) ov_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sample(input int digit, input logic [6:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            sample_en = 1'b1;
            dig_sel   = ND'(1 << digit);
            sseg      = s;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_en = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            sample_en = 1'b0;
            k++;
        end while (out_valid !== 1'b1 && k < 40);
        check({name, "_frame_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            sample_en = 1'b0;
            if (out_valid === 1'b1) seen++;
        end
    endtask

    initial begin
        int seen, ov_base;
        logic [ND-1:0] rsel;
        logic [6:0]    rseg;
        int            r, hold;

        repeat (2) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_bcd",   32'(bcd_out),   32'd0);
        rst_n = 1'b1;
        idle(2);

        // Plain frame 4321
        for (int d = 0; d < ND; d++) sample(d, SEG[d+1], SC);
        wait_valid("f4321");
        check("f4321_bcd",   32'(bcd_out), 32'h4321);
        check("f4321_blank", 32'(blank),   32'd0);
        check("f4321_err",   32'(err),     32'd0);
        idle(3);

        // Interrupted run on digit0: the 1 never commits, the 0 does
        sample(0, SEG[1], 2);
        sample(0, SEG[0], SC);
        for (int d = 1; d < ND; d++) sample(d, SEG[d], SC);
        wait_valid("f3210");
        check("f3210_bcd", 32'(bcd_out), 32'h3210);
        idle(3);

        // Illegal and dark digits
        sample(0, SEG[5], SC);
        sample(1, SEG[6], SC);
        sample(2, 7'b1000000, SC);
        sample(3, 7'b0000000, SC);
        wait_valid("fE_F");
        check("fE_F_bcd",   32'(bcd_out), 32'hFE65);
        check("fE_F_err",   32'(err),     32'b0100);
        check("fE_F_blank", 32'(blank),   32'b1000);
        idle(3);

        // Stalled consumer, overrun, then release
        out_ready = 1'b0;
        for (int d = 0; d < ND; d++) sample(d, SEG[d+1], SC);
        wait_valid("stall");
        ov_base = ov_seen;
        for (int d = 0; d < ND; d++) sample(d, SEG[d+5], SC);
        idle(2);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_bcd",   32'(bcd_out),   32'h4321);
        sample(0, SEG[9], SC);
        idle(3);
        check("overrun_once", 32'(ov_seen - ov_base), 32'd1);
        check("stall_hold_bcd2", 32'(bcd_out), 32'h4321);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("released_valid", 32'(out_valid), 32'd1);
        check("released_bcd",   32'(bcd_out),   32'h8769);
        idle(4);

        // Multi-hot select clears the run counter
        sample(0, SEG[1], SC);
        sample(2, SEG[2], SC);
        sample(3, SEG[3], SC);
        sample(1, SEG[7], 2);
        @(negedge clk);
        sample_en = 1'b1; dig_sel = 4'b0011; sseg = SEG[7];
        sample(1, SEG[7], 2);
        count_valid(6, seen);
        check("multihot_no_frame", 32'(seen), 32'd0);
        sample(1, SEG[7], 1);
        wait_valid("multihot");
        check("multihot_bcd", 32'(bcd_out), 32'h3271);
        idle(3);

        // Reset with a partial frame pending
        sample(0, SEG[9], SC);
        sample(1, SEG[9], SC);
        @(negedge clk);
        sample_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd",   32'(bcd_out),   32'd0);
        check("rst_blank", 32'(blank),     32'd0);
        check("rst_err",   32'(err),       32'd0);
        sample(2, SEG[7], SC);
        sample(3, SEG[8], SC);
        count_valid(6, seen);
        check("rst_no_stale_frame", 32'(seen), 32'd0);
        sample(0, SEG[1], SC);
        sample(1, SEG[0], SC);
        wait_valid("post_rst");
        check("post_rst_bcd", 32'(bcd_out), 32'h8701);
        idle(3);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) rsel = '0;
            else if (r == 1) begin
                rsel = ND'($urandom);
                if ($countones(rsel) == 1) rsel = '1;
            end else rsel = ND'(1 << $urandom_range(0, ND-1));
            r = $urandom_range(0, 11);
            if (r < 10) rseg = SEG[r];
            else if (r == 10) rseg = 7'd0;
            else rseg = 7'($urandom);
            hold = $urandom_range(1, 5);
            repeat (hold) begin
                @(negedge clk);
                sample_en = ($urandom_range(0, 3) != 0);
                dig_sel   = rsel;
                sseg      = rseg;
                out_ready = ($urandom_range(0, 2) != 0);
                rst_n     = ($urandom_range(0, 399) != 0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
